// File: rtl/ibus_if.sv
// rtl/ibus_if.sv - instruction bus request/grant/read-data interface
// Purpose: groups the instruction-bus handshake between the fetch stage and memory.
// Signals:
//   req    master->slave  read request, addr valid
//   addr   master->slave  word-aligned read address
//   gnt    slave->master  address accepted this cycle (req & gnt)
//   rvalid slave->master  read data valid, one per accepted request
//   rdata  slave->master  read data
interface ibus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF-stage fetch sequencer between PC register and instruction bus
// Purpose: issues one aligned read per PC value, pulses pc_en_o when the address is
// accepted (or when a misaligned PC is turned into an address-error instruction),
// and registers the returned word with its PC for the IF/ID latch.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   pc_i           current fetch PC
//   pc_en_o        one-cycle pulse, PC register advances on the next edge
//   flush_i        redirect, discard the pending or held instruction
//   stall_i        IF/ID not accepting this cycle
//   ibus           instruction bus (master side)
//   inst_valid_o   inst_o / inst_pc_o / inst_adel_o valid
//   inst_o         fetched instruction (0 on address error)
//   inst_pc_o      PC of inst_o
//   inst_adel_o    fetch address error (pc_i[1:0] != 0)
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_en_o,
  input  logic              flush_i,
  input  logic              stall_i,
  ibus_if.master            ibus,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_adel_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inst_valid_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_adel_q;

  logic pc_misaligned;
  logic in_req;
  logic bus_req;

  assign pc_misaligned = (pc_i[1:0] != 2'b00);
  assign in_req        = (state_q == S_REQ);
  assign bus_req       = in_req && !pc_misaligned;

  // The PC only moves on pc_en_o, so driving the address straight from pc_i keeps
  // it stable for as long as the request waits for a grant.
  assign ibus.req  = bus_req;
  assign ibus.addr = bus_req ? {pc_i[ADDR_W-1:2], 2'b00} : '0;

  // Combinational so the PC register advances on the same edge the address is
  // accepted. A misaligned PC pulses unconditionally: it never touches the bus,
  // and a concurrent flush still has to let the PC register move on.
  assign pc_en_o = in_req && (pc_misaligned || ibus.gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_pc_q     <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_adel_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
        end

        S_REQ: begin
          if (pc_misaligned) begin
            // Address error becomes an instruction of its own, unless the
            // redirect already made it irrelevant.
            if (!flush_i) begin
              inst_valid_q <= 1'b1;
              inst_adel_q  <= 1'b1;
              inst_q       <= '0;
              inst_pc_q    <= pc_i;
              state_q      <= S_OUT;
            end
          end else if (ibus.gnt) begin
            req_pc_q <= pc_i;
            state_q  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (ibus.rvalid) begin
            if (!flush_i) begin
              inst_valid_q <= 1'b1;
              inst_adel_q  <= 1'b0;
              inst_q       <= ibus.rdata;
              inst_pc_q    <= req_pc_q;
              state_q      <= S_OUT;
            end else begin
              state_q <= S_REQ;
            end
          end else if (flush_i) begin
            // The read is still in flight; its data must be swallowed before a
            // new request can go out.
            state_q <= S_DROP;
          end
        end

        S_DROP: begin
          if (ibus.rvalid) begin
            state_q <= S_REQ;
          end
        end

        S_OUT: begin
          if (flush_i || !stall_i) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_REQ;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_adel_o  = inst_adel_q;

`ifndef SYNTHESIS
  // Read data may only arrive while a request is outstanding.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    ibus.rvalid |-> (state_q == S_WAIT || state_q == S_DROP));
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
// Reference model is transaction level: a fetch may issue when nothing is in flight
// and no instruction is held; a flush after acceptance kills the in-flight read; a
// held instruction leaves on !stall or flush. Memory returns addr ^ 32'h9bc10001.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i;
  logic        stall_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_adel_o;

  ibus_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  inst_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_en_o      (pc_en_o),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .ibus         (bus),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_adel_o  (inst_adel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // model state
  logic        idle;
  logic        pending;
  logic        killed;
  int          rv_wait;
  logic [31:0] pend_pc;
  logic        slot_v;
  logic [31:0] slot_inst;
  logic [31:0] slot_pc;
  logic        slot_adel;
  logic [31:0] pc;
  int          pen_cnt;
  logic        valid_seen;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h9bc10001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input logic r, input logic f, input logic s, input logic g, input int k);
    logic rv, mis, can, exp_req, exp_pen;
    rst     = r;
    flush_i = f;
    stall_i = s;
    pc_i    = pc;
    bus.gnt = g;
    rv = pending && (rv_wait == 0);
    bus.rvalid = rv;
    bus.rdata  = rv ? mem(pend_pc) : $urandom;
    #2;
    mis     = (pc[1:0] != 2'b00);
    can     = !idle && !pending && !slot_v;
    exp_req = can && !mis;
    exp_pen = can && (mis || g);
    chk("ibus_req", {31'd0, bus.req}, {31'd0, exp_req});
    chk("ibus_addr", bus.addr, exp_req ? {pc[31:2], 2'b00} : 32'd0);
    chk("pc_en", {31'd0, pc_en_o}, {31'd0, exp_pen});
    chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, slot_v});
    if (slot_v) begin
      chk("inst", inst_o, slot_inst);
      chk("inst_pc", inst_pc_o, slot_pc);
      chk("inst_adel", {31'd0, inst_adel_o}, {31'd0, slot_adel});
    end
    if (pc_en_o) pen_cnt++;
    if (inst_valid_o) valid_seen = 1'b1;
    @(posedge clk);
    if (r) begin
      idle    = 1'b1;
      pending = 1'b0;
      killed  = 1'b0;
      slot_v  = 1'b0;
    end else begin
      if (slot_v && (f || !s)) slot_v = 1'b0;
      if (idle) begin
        idle = 1'b0;
      end else if (can) begin
        if (mis) begin
          if (!f) begin
            slot_v = 1'b1; slot_inst = 32'd0; slot_pc = pc; slot_adel = 1'b1;
          end
        end else if (g) begin
          pending = 1'b1; killed = 1'b0; pend_pc = pc; rv_wait = k - 1;
        end
      end else if (pending) begin
        if (rv) begin
          if (!(killed || f)) begin
            slot_v = 1'b1; slot_inst = mem(pend_pc); slot_pc = pend_pc; slot_adel = 1'b0;
          end
          pending = 1'b0;
        end else begin
          if (f) killed = 1'b1;
          rv_wait--;
        end
      end
      if (exp_pen) pc = pc + 32'd4;
    end
    #1;
  endtask

  initial begin
    int pen0;
    logic [31:0] rnd;
    logic f, s, g;
    int k;
    total = 0; bad = 0; pen_cnt = 0; valid_seen = 1'b0;
    idle = 1'b1; pending = 1'b0; killed = 1'b0; rv_wait = 0; pend_pc = '0;
    slot_v = 1'b0; slot_inst = '0; slot_pc = '0; slot_adel = 1'b0;
    pc = 32'hbfc00000;
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0; pc_i = pc;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then first fetch with immediate grant and 1-cycle read latency
    cyc(1, 0, 0, 0, 1);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_adel", {31'd0, inst_adel_o}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    pen0 = pen_cnt;
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    chk("first_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("first_pc", inst_pc_o, 32'hbfc00000);
    chk("first_inst", inst_o, 32'h24010001);
    chk("first_pulses", pen_cnt - pen0, 32'd1);

    // consume, then hold off the grant for 3 cycles
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("nogrant_req", {31'd0, bus.req}, 32'd1);
      chk("nogrant_addr", bus.addr, 32'hbfc00004);
      chk("nogrant_pen", {31'd0, pc_en_o}, 32'd0);
    end
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);

    // stall 4 cycles in OUT
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 1);
    chk("stall_pc", inst_pc_o, 32'hbfc00004);
    chk("stall_inst", inst_o, mem(32'hbfc00004));
    chk("stall_noreq", {31'd0, bus.req}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("release_req", {31'd0, bus.req}, 32'd1);

    // flush during WAIT, data arrives 2 cycles later and is dropped
    cyc(0, 0, 0, 1, 3);
    valid_seen = 1'b0;
    cyc(0, 1, 0, 0, 1);
    pc = 32'hbfc00002;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("drop_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("drop_never_valid", {31'd0, valid_seen}, 32'd0);

    // misaligned PC
    pen0 = pen_cnt;
    cyc(0, 0, 0, 1, 1);
    chk("adel_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("adel_flag", {31'd0, inst_adel_o}, 32'd1);
    chk("adel_inst", inst_o, 32'd0);
    chk("adel_pc", inst_pc_o, 32'hbfc00002);
    chk("adel_pulses", pen_cnt - pen0, 32'd1);

    // reset while waiting for read data
    pc = 32'hbfc00010;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 2);
    cyc(1, 0, 0, 0, 1);
    chk("midrst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("midrst_inst", inst_o, 32'd0);
    chk("midrst_pc", inst_pc_o, 32'd0);
    chk("midrst_adel", {31'd0, inst_adel_o}, 32'd0);
    chk("midrst_req", {31'd0, bus.req}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("midrst_then_req", {31'd0, bus.req}, 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      f = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 2) == 0);
      g = $urandom_range(0, 1) == 1;
      k = $urandom_range(1, 3);
      cyc(0, f, s, g, k);
      if (f) begin
        rnd = $urandom;
        pc = ($urandom_range(0, 9) == 0) ? {rnd[31:2], 2'b10} : {rnd[31:2], 2'b00};
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
